// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory stage: pipeline state, Funct3 size/sign
// encoding, alignment check and store-lane construction.
package mem_stage_pkg;

   localparam int XLEN = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   // Funct3[1:0] selects the access size, Funct3[2] selects zero-extension on loads.
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;
   localparam int         F3_UNSIGNED_BIT = 2;
   localparam logic [2:0] F3_INVALID = 3'b111;

   function automatic logic isMisaligned(input logic [2:0] funct3, input logic [2:0] addrLow);
      logic bad;
      case (funct3[1:0])
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = addrLow[0];
         SIZE_W:  bad = |addrLow[1:0];
         default: bad = |addrLow;
      endcase
      if (funct3 == F3_INVALID) begin
         bad = 1'b1;
      end
      return bad;
   endfunction

   function automatic logic [7:0] sizeMask(input logic [1:0] size);
      logic [7:0] mask;
      case (size)
         SIZE_B:  mask = 8'h01;
         SIZE_H:  mask = 8'h03;
         SIZE_W:  mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

   // Copying the store operand into every lane lets the strobe alone pick the bytes.
   function automatic logic [XLEN-1:0] replicateStore(input logic [1:0] size,
                                                      input logic [XLEN-1:0] data);
      logic [XLEN-1:0] lanes;
      case (size)
         SIZE_B:  lanes = {8{data[7:0]}};
         SIZE_H:  lanes = {4{data[15:0]}};
         SIZE_W:  lanes = {2{data[31:0]}};
         default: lanes = data;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: moves the addressed bytes of a 64-bit memory word
// down to bit 0 and sign- or zero-extends them according to Funct3.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]      i_funct3,
   input  logic [2:0]      i_addrLow,
   input  logic [XLEN-1:0] i_rdata,
   output logic [XLEN-1:0] o_loadData
);

   logic [XLEN-1:0] w_shifted;
   logic            w_signed;

   assign w_shifted = i_rdata >> {i_addrLow, 3'b000};
   assign w_signed  = ~i_funct3[F3_UNSIGNED_BIT];

   always_comb begin
      o_loadData = w_shifted;
      case (i_funct3[1:0])
         SIZE_B:  o_loadData = {{(XLEN-8){w_shifted[7] & w_signed}}, w_shifted[7:0]};
         SIZE_H:  o_loadData = {{(XLEN-16){w_shifted[15] & w_signed}}, w_shifted[15:0]};
         SIZE_W:  o_loadData = {{(XLEN-32){w_shifted[31] & w_signed}}, w_shifted[31:0]};
         default: o_loadData = w_shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: captures an execute result, runs at most one data-memory
// transaction with a req/gnt/rvalid handshake, and presents a one-cycle writeback result.
module mem_stage #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] ALUResult,
   input  logic [XLEN-1:0] StoreData,
   input  logic [4:0]      Rd,
   input  logic            MemRead,
   input  logic            MemWrite,
   input  logic            MemtoReg,
   input  logic            RegWrite,
   input  logic [2:0]      Funct3,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [7:0]      dmem_wstrb,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            out_valid,
   output logic [XLEN-1:0] ReadData,
   output logic [XLEN-1:0] ALUResultOut,
   output logic [4:0]      RdOut,
   output logic            MemtoRegOut,
   output logic            RegWriteOut,
   output logic            misaligned
);

   import mem_stage_pkg::*;

   state_t          r_state;
   state_t          w_nextState;

   logic [XLEN-1:0] r_aluResult;
   logic [XLEN-1:0] r_storeData;
   logic [XLEN-1:0] r_readData;
   logic [4:0]      r_rd;
   logic [2:0]      r_funct3;
   logic            r_memWrite;
   logic            r_memtoReg;
   logic            r_regWrite;
   logic            r_misaligned;

   logic            w_accept;
   logic            w_inMemOp;
   logic            w_inMisaligned;
   logic            w_loadDone;
   logic [XLEN-1:0] w_loadData;

   // Gating with reset keeps in_ready low for the whole reset window even though the
   // state register already sits in IDLE.
   assign in_ready       = ~reset & ((r_state == IDLE) | (r_state == DONE));
   assign w_accept       = in_valid & in_ready;
   assign w_inMemOp      = MemRead | MemWrite;
   assign w_inMisaligned = w_inMemOp & isMisaligned(Funct3, ALUResult[2:0]);

   assign w_loadDone = ~r_memWrite & dmem_rvalid &
                       (((r_state == REQ) & dmem_gnt) | (r_state == WAIT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (w_accept) begin
               w_nextState = (w_inMemOp & ~w_inMisaligned) ? REQ : DONE;
            end else begin
               w_nextState = IDLE;
            end
         end
         REQ: begin
            if (dmem_gnt) begin
               w_nextState = (r_memWrite | dmem_rvalid) ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (dmem_rvalid) begin
               w_nextState = DONE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // ReadData is cleared on every accept so stores, ALU ops and faults report zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_aluResult  <= '0;
         r_storeData  <= '0;
         r_readData   <= '0;
         r_rd         <= '0;
         r_funct3     <= '0;
         r_memWrite   <= 1'b0;
         r_memtoReg   <= 1'b0;
         r_regWrite   <= 1'b0;
         r_misaligned <= 1'b0;
      end else if (w_accept) begin
         r_aluResult  <= ALUResult;
         r_storeData  <= StoreData;
         r_readData   <= '0;
         r_rd         <= Rd;
         r_funct3     <= Funct3;
         r_memWrite   <= MemWrite;
         r_memtoReg   <= MemtoReg;
         r_regWrite   <= RegWrite;
         r_misaligned <= w_inMisaligned;
      end else if (w_loadDone) begin
         r_readData   <= w_loadData;
      end
   end

   load_align u_loadAlign (
      .i_funct3   (r_funct3),
      .i_addrLow  (r_aluResult[2:0]),
      .i_rdata    (dmem_rdata),
      .o_loadData (w_loadData)
   );

   assign dmem_req   = (r_state == REQ);
   assign dmem_we    = dmem_req & r_memWrite;
   assign dmem_addr  = dmem_req ? {r_aluResult[XLEN-1:3], 3'b000} : '0;
   assign dmem_wstrb = dmem_we ? (sizeMask(r_funct3[1:0]) << r_aluResult[2:0]) : 8'h00;
   assign dmem_wdata = dmem_we ? replicateStore(r_funct3[1:0], r_storeData) : '0;

   // Result fields read as zero outside the valid cycle so writeback never sees stale data.
   assign out_valid    = (r_state == DONE);
   assign ReadData     = out_valid ? r_readData : '0;
   assign ALUResultOut = out_valid ? r_aluResult : '0;
   assign RdOut        = out_valid ? r_rd : '0;
   assign MemtoRegOut  = out_valid & r_memtoReg;
   assign RegWriteOut  = out_valid & r_regWrite & ~r_misaligned;
   assign misaligned   = out_valid & r_misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a table of single transactions with a simple
// memory responder, plus hand-written sequences for stalls, reset and back-to-back flow.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] ALUResult;
   logic [63:0] StoreData;
   logic [4:0]  Rd;
   logic        MemRead, MemWrite, MemtoReg, RegWrite;
   logic [2:0]  Funct3;
   logic        dmem_req, dmem_we;
   logic [63:0] dmem_addr, dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic        dmem_gnt, dmem_rvalid;
   logic [63:0] dmem_rdata;
   logic        out_valid;
   logic [63:0] ReadData, ALUResultOut;
   logic [4:0]  RdOut;
   logic        MemtoRegOut, RegWriteOut, misaligned;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        memRead, memWrite, memtoReg, regWrite;
      logic [2:0]  funct3;
      logic [63:0] addr, storeData, rdata;
      logic [4:0]  rd;
      logic        expReq;
      logic [63:0] expAddr;
      logic [7:0]  expWstrb;
      logic [63:0] expWdata, expReadData;
      logic        expMis, expRegWriteOut;
   } vec_t;

   vec_t vecs[15];

   mem_stage #(.XLEN(64)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .ALUResult(ALUResult), .StoreData(StoreData), .Rd(Rd),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .Funct3(Funct3), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .out_valid(out_valid),
      .ReadData(ReadData), .ALUResultOut(ALUResultOut), .RdOut(RdOut),
      .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mkVec(input logic rdF, input logic wrF, input logic [2:0] f3,
                                  input logic [63:0] addr, input logic [63:0] sd,
                                  input logic [63:0] rdata, input logic [4:0] rd,
                                  input logic rw, input logic m2r, input logic expReq,
                                  input logic [63:0] expAddr, input logic [7:0] expWstrb,
                                  input logic [63:0] expWdata, input logic [63:0] expRd,
                                  input logic expMis, input logic expRwo);
      vec_t v;
      v.memRead = rdF;       v.memWrite = wrF;     v.funct3 = f3;
      v.addr = addr;         v.storeData = sd;     v.rdata = rdata;
      v.rd = rd;             v.regWrite = rw;      v.memtoReg = m2r;
      v.expReq = expReq;     v.expAddr = expAddr;  v.expWstrb = expWstrb;
      v.expWdata = expWdata; v.expReadData = expRd;
      v.expMis = expMis;     v.expRegWriteOut = expRwo;
      return v;
   endfunction

   task automatic driveInputs(input vec_t v);
      in_valid  = 1'b1;
      ALUResult = v.addr;
      StoreData = v.storeData;
      Rd        = v.rd;
      MemRead   = v.memRead;
      MemWrite  = v.memWrite;
      MemtoReg  = v.memtoReg;
      RegWrite  = v.regWrite;
      Funct3    = v.funct3;
   endtask

   task automatic applyStimulus(input vec_t v);
      int n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      checkValue("ready_before_issue", {63'd0, in_ready}, 64'd1);
      driveInputs(v);
      step();
      in_valid = 1'b0;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      checkValue($sformatf("v%0d_ReadData", idx), ReadData, v.expReadData);
      checkValue($sformatf("v%0d_ALUResultOut", idx), ALUResultOut, v.addr);
      checkValue($sformatf("v%0d_RdOut", idx), {59'd0, RdOut}, {59'd0, v.rd});
      checkValue($sformatf("v%0d_MemtoRegOut", idx), {63'd0, MemtoRegOut}, {63'd0, v.memtoReg});
      checkValue($sformatf("v%0d_RegWriteOut", idx), {63'd0, RegWriteOut}, {63'd0, v.expRegWriteOut});
      checkValue($sformatf("v%0d_misaligned", idx), {63'd0, misaligned}, {63'd0, v.expMis});
   endtask

   task automatic checkQuiet(input string tag);
      checkValue({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
      checkValue({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
      checkValue({tag, "_dmem_req"}, {63'd0, dmem_req}, 64'd0);
      checkValue({tag, "_dmem_we"}, {63'd0, dmem_we}, 64'd0);
      checkValue({tag, "_dmem_addr"}, dmem_addr, 64'd0);
      checkValue({tag, "_dmem_wstrb"}, {56'd0, dmem_wstrb}, 64'd0);
      checkValue({tag, "_dmem_wdata"}, dmem_wdata, 64'd0);
      checkValue({tag, "_ReadData"}, ReadData, 64'd0);
      checkValue({tag, "_ALUResultOut"}, ALUResultOut, 64'd0);
      checkValue({tag, "_RdOut"}, {59'd0, RdOut}, 64'd0);
      checkValue({tag, "_MemtoRegOut"}, {63'd0, MemtoRegOut}, 64'd0);
      checkValue({tag, "_RegWriteOut"}, {63'd0, RegWriteOut}, 64'd0);
      checkValue({tag, "_misaligned"}, {63'd0, misaligned}, 64'd0);
   endtask

   task automatic runVector(input vec_t v, input int idx);
      logic sawReq;
      logic sawValid;
      applyStimulus(v);
      sawReq   = 1'b0;
      sawValid = 1'b0;
      for (int c = 0; c < 20 && !sawValid; c++) begin
         dmem_gnt    = 1'b0;
         dmem_rvalid = 1'b0;
         if (out_valid) begin
            checkOutput(v, idx);
            sawValid = 1'b1;
         end else begin
            if (dmem_req) begin
               if (!sawReq) begin
                  checkValue($sformatf("v%0d_dmem_addr", idx), dmem_addr, v.expAddr);
                  checkValue($sformatf("v%0d_dmem_we", idx), {63'd0, dmem_we}, {63'd0, v.memWrite});
                  checkValue($sformatf("v%0d_dmem_wstrb", idx), {56'd0, dmem_wstrb}, {56'd0, v.expWstrb});
                  checkValue($sformatf("v%0d_dmem_wdata", idx), dmem_wdata, v.expWdata);
               end
               sawReq   = 1'b1;
               dmem_gnt = 1'b1;
            end else if (sawReq) begin
               dmem_rvalid = 1'b1;
               dmem_rdata  = v.rdata;
            end
            step();
         end
      end
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      checkValue($sformatf("v%0d_result_seen", idx), {63'd0, sawValid}, 64'd1);
      checkValue($sformatf("v%0d_req_issued", idx), {63'd0, sawReq}, {63'd0, v.expReq});
      step();
      checkValue($sformatf("v%0d_pulse_end", idx), {63'd0, out_valid}, 64'd0);
      checkValue($sformatf("v%0d_regwrite_idle", idx), {63'd0, RegWriteOut}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      //            rd wr f3      addr                   storeData              rdata                  rd rw m2r req expAddr       wstrb  expWdata               expReadData           mis rwo
      vecs[0]  = mkVec(0, 0, 3'b000, 64'hBBBBBBBBBBBBBBBB, 64'h0, 64'h0, 5'd7, 1, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 0, 1);
      vecs[1]  = mkVec(1, 0, 3'b000, 64'h1003, 64'h0, 64'h0000000080000000, 5'd5, 1, 1, 1, 64'h1000, 8'h00, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 1);
      vecs[2]  = mkVec(0, 1, 3'b001, 64'h2006, 64'h1234, 64'h0, 5'd0, 0, 0, 1, 64'h2000, 8'hC0, 64'h1234123412341234, 64'h0, 0, 0);
      vecs[3]  = mkVec(1, 0, 3'b010, 64'h3002, 64'h0, 64'hFFFFFFFFFFFFFFFF, 5'd9, 1, 1, 0, 64'h0, 8'h00, 64'h0, 64'h0, 1, 0);
      vecs[4]  = mkVec(1, 0, 3'b110, 64'h4004, 64'h0, 64'hFFFFFFFF00000000, 5'd10, 1, 1, 1, 64'h4000, 8'h00, 64'h0, 64'h00000000FFFFFFFF, 0, 1);
      vecs[5]  = mkVec(1, 0, 3'b001, 64'h5002, 64'h0, 64'h0000000080010000, 5'd11, 1, 1, 1, 64'h5000, 8'h00, 64'h0, 64'hFFFFFFFFFFFF8001, 0, 1);
      vecs[6]  = mkVec(1, 0, 3'b101, 64'h5006, 64'h0, 64'h8001000000000000, 5'd12, 1, 1, 1, 64'h5000, 8'h00, 64'h0, 64'h0000000000008001, 0, 1);
      vecs[7]  = mkVec(0, 1, 3'b000, 64'h6005, 64'hFFFFFFFFFFFFFFAB, 64'h0, 5'd0, 0, 0, 1, 64'h6000, 8'h20, 64'hABABABABABABABAB, 64'h0, 0, 0);
      vecs[8]  = mkVec(0, 1, 3'b011, 64'h7000, 64'h0123456789ABCDEF, 64'h0, 5'd0, 0, 0, 1, 64'h7000, 8'hFF, 64'h0123456789ABCDEF, 64'h0, 0, 0);
      vecs[9]  = mkVec(1, 0, 3'b011, 64'h8008, 64'h0, 64'hDEADBEEFCAFEF00D, 5'd13, 1, 1, 1, 64'h8008, 8'h00, 64'h0, 64'hDEADBEEFCAFEF00D, 0, 1);
      vecs[10] = mkVec(1, 0, 3'b010, 64'h9004, 64'h0, 64'h8000000000000000, 5'd14, 1, 1, 1, 64'h9000, 8'h00, 64'h0, 64'hFFFFFFFF80000000, 0, 1);
      vecs[11] = mkVec(1, 0, 3'b111, 64'hA000, 64'h0, 64'h0, 5'd15, 1, 1, 0, 64'h0, 8'h00, 64'h0, 64'h0, 1, 0);
      vecs[12] = mkVec(1, 0, 3'b100, 64'h1007, 64'h0, 64'hF000000000000000, 5'd16, 1, 1, 1, 64'h1000, 8'h00, 64'h0, 64'h00000000000000F0, 0, 1);
      vecs[13] = mkVec(0, 1, 3'b010, 64'h300C, 64'hCAFEBABEDEADBEEF, 64'h0, 5'd0, 0, 0, 1, 64'h3008, 8'hF0, 64'hDEADBEEFDEADBEEF, 64'h0, 0, 0);
      vecs[14] = mkVec(0, 1, 3'b011, 64'h7004, 64'h55, 64'h0, 5'd17, 1, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 1, 0);

      reset = 1'b1;
      in_valid = 1'b0; ALUResult = '0; StoreData = '0; Rd = '0;
      MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0; Funct3 = '0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

      // Reset state and release
      step();
      step();
      checkQuiet("reset");
      reset = 1'b0;
      step();
      checkValue("ready_after_reset", {63'd0, in_ready}, 64'd1);

      // Stray handshake signals while idle must be ignored
      dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 64'hFFFFFFFFFFFFFFFF;
      step();
      checkValue("idle_gnt_out_valid", {63'd0, out_valid}, 64'd0);
      checkValue("idle_gnt_in_ready", {63'd0, in_ready}, 64'd1);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;

      for (int i = 0; i < 15; i++) begin
         runVector(vecs[i], i);
      end

      // LB with grant and data each arriving late
      applyStimulus(vecs[1]);
      checkValue("late_req0", {63'd0, dmem_req}, 64'd1);
      checkValue("late_busy_ready", {63'd0, in_ready}, 64'd0);
      step();
      checkValue("late_req1", {63'd0, dmem_req}, 64'd1);
      checkValue("late_addr1", dmem_addr, 64'h1000);
      step();
      checkValue("late_req2", {63'd0, dmem_req}, 64'd1);
      dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0;
      checkValue("late_wait_req", {63'd0, dmem_req}, 64'd0);
      checkValue("late_wait_valid", {63'd0, out_valid}, 64'd0);
      checkValue("late_wait_ready", {63'd0, in_ready}, 64'd0);
      step();
      checkValue("late_wait2_valid", {63'd0, out_valid}, 64'd0);
      dmem_rvalid = 1'b1; dmem_rdata = 64'h0000000080000000;
      step();
      dmem_rvalid = 1'b0;
      checkValue("late_out_valid", {63'd0, out_valid}, 64'd1);
      checkValue("late_ReadData", ReadData, 64'hFFFFFFFFFFFFFF80);
      checkValue("late_RegWriteOut", {63'd0, RegWriteOut}, 64'd1);
      step();
      checkValue("late_pulse_end", {63'd0, out_valid}, 64'd0);

      // LD with gnt and rvalid in the same cycle goes straight to the result
      applyStimulus(vecs[9]);
      checkValue("same_req", {63'd0, dmem_req}, 64'd1);
      dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 64'h0011223344556677;
      step();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      checkValue("same_out_valid", {63'd0, out_valid}, 64'd1);
      checkValue("same_ReadData", ReadData, 64'h0011223344556677);
      step();

      // Reset while waiting for load data abandons the transaction
      applyStimulus(vecs[9]);
      dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0;
      checkValue("rstwait_req", {63'd0, dmem_req}, 64'd0);
      #2 reset = 1'b1;
      #1 checkQuiet("rstwait");
      step();
      reset = 1'b0;
      dmem_rvalid = 1'b1; dmem_rdata = 64'h1234567812345678;
      step();
      dmem_rvalid = 1'b0;
      checkValue("rstwait_late_rvalid", {63'd0, out_valid}, 64'd0);
      step();
      checkValue("rstwait_late_rvalid2", {63'd0, out_valid}, 64'd0);
      checkValue("rstwait_ready", {63'd0, in_ready}, 64'd1);

      // Back-to-back: ALU, ALU, then LWU accepted in the DONE cycles
      applyStimulus(mkVec(0, 0, 3'b000, 64'h1111, 64'h0, 64'h0, 5'd3, 1, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 0, 1));
      checkValue("b2b_a_valid", {63'd0, out_valid}, 64'd1);
      checkValue("b2b_a_alu", ALUResultOut, 64'h1111);
      checkValue("b2b_a_ready", {63'd0, in_ready}, 64'd1);
      driveInputs(mkVec(0, 0, 3'b000, 64'h2222, 64'h0, 64'h0, 5'd4, 1, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 0, 1));
      step();
      checkValue("b2b_b_valid", {63'd0, out_valid}, 64'd1);
      checkValue("b2b_b_alu", ALUResultOut, 64'h2222);
      checkValue("b2b_b_rd", {59'd0, RdOut}, 64'd4);
      driveInputs(vecs[4]);
      step();
      in_valid = 1'b0;
      checkValue("b2b_c_req", {63'd0, dmem_req}, 64'd1);
      checkValue("b2b_c_valid_low", {63'd0, out_valid}, 64'd0);
      dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 64'hFFFFFFFF00000000;
      step();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      checkValue("b2b_c_valid", {63'd0, out_valid}, 64'd1);
      checkValue("b2b_c_ReadData", ReadData, 64'h00000000FFFFFFFF);
      step();
      checkValue("b2b_c_pulse_end", {63'd0, out_valid}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
